// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel datapath: image geometry defaults,
// window width and the bit offsets of each tap inside the packed window.
package sobel_pkg;

   localparam int IMG_W_DEF = 640;
   localparam int IMG_H_DEF = 480;
   localparam int PIX_W_DEF = 8;
   localparam int WIN_W     = 9 * PIX_W_DEF;

   // Row-major packing: tap (0,0) is top-left and sits in the MSBs.
   function automatic int tap_lsb(input int r, input int c, input int pw);
      return (8 - (3 * r + c)) * pw;
   endfunction

   localparam int TAP_00 = tap_lsb(0, 0, PIX_W_DEF);
   localparam int TAP_01 = tap_lsb(0, 1, PIX_W_DEF);
   localparam int TAP_02 = tap_lsb(0, 2, PIX_W_DEF);
   localparam int TAP_10 = tap_lsb(1, 0, PIX_W_DEF);
   localparam int TAP_11 = tap_lsb(1, 1, PIX_W_DEF);
   localparam int TAP_12 = tap_lsb(1, 2, PIX_W_DEF);
   localparam int TAP_20 = tap_lsb(2, 0, PIX_W_DEF);
   localparam int TAP_21 = tap_lsb(2, 1, PIX_W_DEF);
   localparam int TAP_22 = tap_lsb(2, 2, PIX_W_DEF);

endpackage

// File: rtl/sobel_line_ram.sv
// Two-line history buffer: one entry per column holding the pixels
// of the previous two rows. Asynchronous read, synchronous write.
module sobel_line_ram #(
   parameter int DEPTH = 640,
   parameter int DW    = 16,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];

   assign rdata_o = mem_q[addr_i];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: raster pixels in, one packed
// neighbourhood out per interior pixel, with a one-deep output stage.
module sobel_window_gen
   import sobel_pkg::*;
#(
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF,
   parameter int PIX_W = PIX_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PIX_W-1:0]   pix_in,
   input  logic               pix_valid,
   output logic               pix_ready,
   output logic [9*PIX_W-1:0] win_out,
   output logic               win_valid,
   input  logic               win_ready,
   output logic               frame_done
);

   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

   logic [CW-1:0]      col_q, col_d;
   logic [RW-1:0]      row_q, row_d;
   logic               vld_q, vld_d;
   logic               last_q, last_d;
   logic [PIX_W-1:0]   w_q [3][3];
   logic [2*PIX_W-1:0] ram_rd;
   logic [PIX_W-1:0]   line1, line2;
   logic               accept, emit;
   logic               col_end, row_end;

   assign pix_ready = !vld_q || win_ready;
   assign accept    = pix_valid && pix_ready;
   assign col_end   = (col_q == CW'(IMG_W - 1));
   assign row_end   = (row_q == RW'(IMG_H - 1));
   assign emit      = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
   assign {line1, line2} = ram_rd;

   sobel_line_ram #(
      .DEPTH (IMG_W),
      .DW    (2 * PIX_W),
      .AW    (CW)
   ) u_line_ram (
      .clk     (clk),
      .we_i    (accept),
      .addr_i  (col_q),
      .wdata_i ({pix_in, line1}),
      .rdata_o (ram_rd)
   );

   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      vld_d  = vld_q;
      last_d = last_q;
      if (vld_q && win_ready) begin
         vld_d = 1'b0;
      end
      if (accept) begin
         vld_d  = emit;
         last_d = col_end && row_end;
         col_d  = col_end ? '0 : col_q + 1'b1;
         if (col_end) begin
            row_d = row_end ? '0 : row_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         col_q  <= '0;
         row_q  <= '0;
         vld_q  <= 1'b0;
         last_q <= 1'b0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         vld_q  <= vld_d;
         last_q <= last_d;
      end
   end

   // Window contents are left unreset; vld_q alone qualifies them.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int r = 0; r < 3; r++) begin
            w_q[r][0] <= w_q[r][1];
            w_q[r][1] <= w_q[r][2];
         end
         w_q[0][2] <= line2;
         w_q[1][2] <= line1;
         w_q[2][2] <= pix_in;
      end
   end

   always_comb begin
      win_out = '0;
      if (vld_q) begin
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_out[tap_lsb(r, c, PIX_W) +: PIX_W] = w_q[r][c];
            end
         end
      end
   end

   assign win_valid  = vld_q;
   assign frame_done = vld_q && win_ready && last_q;

endmodule
